// File: rtl/pcihellocore_display_decoder_pkg.sv
// Shared definitions for the display decoder: FSM encoding, seven-segment
// patterns (active-low, gfedcba) and the double-dabble digit adjust helper.
package pcihellocore_display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_DIGITS = 10;
    localparam int ITER       = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LATCH   = 2'd2
    } state_e;

    // Segment patterns with bit 0 = a; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] b);
        logic [4*BCD_DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcihellocore_display_decoder_if.sv
// Connection between the display PIO (master) and the decoder (slave).
interface pcihellocore_display_decoder_if;

    logic [31:0] value_in;
    logic [55:0] hex_out;
    logic        busy;
    logic        valid;
    logic        overflow;

    modport master (
        output value_in,
        input  hex_out,
        input  busy,
        input  valid,
        input  overflow
    );

    modport slave (
        input  value_in,
        output hex_out,
        output busy,
        output valid,
        output overflow
    );

endinterface

// File: rtl/pcihellocore_display_decoder_seg7_encode.sv
// One decimal digit to seven segments (gfedcba), with blank override and
// selectable output polarity.
module seg7_encode
    import pcihellocore_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] raw_s;

    // Map the digit to its active-low pattern, then apply polarity.
    always_comb begin
        raw_s = SEG_BLANK;
        if (blank) begin
            raw_s = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    raw_s = SEG_0;
                4'd1:    raw_s = SEG_1;
                4'd2:    raw_s = SEG_2;
                4'd3:    raw_s = SEG_3;
                4'd4:    raw_s = SEG_4;
                4'd5:    raw_s = SEG_5;
                4'd6:    raw_s = SEG_6;
                4'd7:    raw_s = SEG_7;
                4'd8:    raw_s = SEG_8;
                4'd9:    raw_s = SEG_9;
                default: raw_s = SEG_BLANK;
            endcase
        end
        if (ACTIVE_LOW) begin
            seg = raw_s;
        end else begin
            seg = ~raw_s;
        end
    end

endmodule

// File: rtl/pcihellocore_display_decoder.sv
// Display decoder: binary value from the display PIO to eight registered
// seven-segment digits via a one-bit-per-clock double-dabble conversion.
module pcihellocore_display_decoder
    import pcihellocore_display_pkg::*;
#(
    parameter bit BLANK_LZ   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    pcihellocore_display_decoder_if.slave  disp
);

    localparam logic [55:0] HEX_OFF = ACTIVE_LOW ? {56{1'b1}} : {56{1'b0}};

    state_e      state_q,    state_d;
    logic [31:0] bin_sr_q,   bin_sr_d;
    logic [39:0] bcd_q,      bcd_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [31:0] last_val_q, last_val_d;
    logic        pending_q,  pending_d;
    logic [55:0] hex_q,      hex_d;
    logic        busy_q,     busy_d;
    logic        valid_q,    valid_d;
    logic        ovf_q,      ovf_d;

    logic        ovf_s;
    logic [7:0]  blank_s;
    logic [55:0] seg_s;
    logic [39:0] bcd_adj_s;
    logic        run_zero_s;

    assign ovf_s     = |bcd_q[39:32];
    assign bcd_adj_s = bcd_adjust(bcd_q);

    // Leading-zero blanking: a digit blanks while it and everything above it
    // is zero; digit 0 always shows and overflow disables blanking entirely.
    always_comb begin
        blank_s    = 8'h00;
        run_zero_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run_zero_s = run_zero_s && (bcd_q[4*k +: 4] == 4'd0);
            if (BLANK_LZ && !ovf_s) begin
                blank_s[k] = run_zero_s;
            end else begin
                blank_s[k] = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_encode #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_seg (
            .digit (bcd_q[4*i +: 4]),
            .blank (blank_s[i]),
            .seg   (seg_s[7*i +: 7])
        );
    end

    // Next-state and next-output computation for the conversion FSM.
    always_comb begin
        state_d    = state_q;
        bin_sr_d   = bin_sr_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        last_val_d = last_val_q;
        pending_d  = pending_q;
        hex_d      = hex_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || (disp.value_in != last_val_q)) begin
                    bin_sr_d   = disp.value_in;
                    last_val_d = disp.value_in;
                    bcd_d      = 40'd0;
                    cnt_d      = 6'd0;
                    pending_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONVERT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                // Adjust first, then shift the binary MSB into BCD bit 0.
                bcd_d    = {bcd_adj_s[38:0], bin_sr_q[31]};
                bin_sr_d = {bin_sr_q[30:0], 1'b0};
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_LATCH: begin
                ovf_d   = ovf_s;
                hex_d   = seg_s;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: drop back to idle and reconvert.
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                pending_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bin_sr_q   <= 32'd0;
            bcd_q      <= 40'd0;
            cnt_q      <= 6'd0;
            last_val_q <= 32'd0;
            pending_q  <= 1'b1;
            hex_q      <= HEX_OFF;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            last_val_q <= last_val_d;
            pending_q  <= pending_d;
            hex_q      <= hex_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign disp.hex_out  = hex_q;
    assign disp.busy     = busy_q;
    assign disp.valid    = valid_q;
    assign disp.overflow = ovf_q;

endmodule

// File: tb/tb_pcihellocore_display_decoder.sv
// Directed bench for the display decoder: table of values with hand-computed
// segment patterns, plus mid-conversion change and mid-conversion reset.
module tb_pcihellocore_display_decoder;

    logic clk;
    logic reset_n;

    pcihellocore_display_decoder_if if_a ();
    pcihellocore_display_decoder_if if_b ();
    pcihellocore_display_decoder_if if_c ();

    // Default build: blanking on, active-low segments.
    pcihellocore_display_decoder #(.BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) u_dut_a (
        .clk (clk), .reset_n (reset_n), .disp (if_a.slave));
    // All digits shown.
    pcihellocore_display_decoder #(.BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) u_dut_b (
        .clk (clk), .reset_n (reset_n), .disp (if_b.slave));
    // Active-high segments.
    pcihellocore_display_decoder #(.BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) u_dut_c (
        .clk (clk), .reset_n (reset_n), .disp (if_c.slave));

    typedef struct {
        logic [31:0] value;
        logic [55:0] exp_lz;
        logic [55:0] exp_all;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check56(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_val(input logic [31:0] v);
        if_a.value_in = v;
        if_b.value_in = v;
        if_c.value_in = v;
    endtask

    // Apply one value at a negedge and check the 33-edge latency window.
    task automatic run_conv(input int idx, input bit release_rst);
        @(negedge clk);
        set_val(vecs[idx].value);
        if (release_rst) reset_n = 1'b1;
        @(posedge clk); #1;                       // edge E
        check1($sformatf("v%0d busy_start", idx), if_a.busy, 1'b1);
        repeat (32) @(posedge clk); #1;           // edge E+32
        check1($sformatf("v%0d busy_e32", idx), if_a.busy, 1'b1);
        @(posedge clk); #1;                       // edge E+33
        check56($sformatf("v%0d hex_lz", idx), if_a.hex_out, vecs[idx].exp_lz);
        check56($sformatf("v%0d hex_all", idx), if_b.hex_out, vecs[idx].exp_all);
        check56($sformatf("v%0d hex_ahigh", idx), if_c.hex_out, ~vecs[idx].exp_lz);
        check1($sformatf("v%0d ovf", idx), if_a.overflow, vecs[idx].exp_ovf);
        check1($sformatf("v%0d ovf_b", idx), if_b.overflow, vecs[idx].exp_ovf);
        check1($sformatf("v%0d valid", idx), if_a.valid, 1'b1);
        check1($sformatf("v%0d busy_end", idx), if_a.busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'd64,         {{6{7'h7F}}, 7'h02, 7'h19}, {{6{7'h40}}, 7'h02, 7'h19}, 1'b0};
        vecs[1] = '{32'd0,          {{7{7'h7F}}, 7'h40},        {8{7'h40}},                 1'b0};
        vecs[2] = '{32'd99999999,   {8{7'h10}},                 {8{7'h10}},                 1'b0};
        vecs[3] = '{32'd100000000,  {8{7'h40}},                 {8{7'h40}},                 1'b1};
        vecs[4] = '{32'd4294967295,
                    {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12},
                    {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}, 1'b1};
        vecs[5] = '{32'd12345,  {{3{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12},
                                {{3{7'h40}}, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b0};
        vecs[6] = '{32'd10203,  {{3{7'h7F}}, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30},
                                {{3{7'h40}}, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30}, 1'b0};
        vecs[7] = '{32'd100000007, {{7{7'h40}}, 7'h78}, {{7{7'h40}}, 7'h78}, 1'b1};
        vecs[8] = '{32'd7,         {{7{7'h7F}}, 7'h78}, {{7{7'h40}}, 7'h78}, 1'b0};

        // Reset state.
        reset_n = 1'b0;
        set_val(32'd64);
        repeat (3) @(posedge clk); #1;
        check56("rst hex_a", if_a.hex_out, {56{1'b1}});
        check56("rst hex_c", if_c.hex_out, 56'h0);
        check1("rst busy", if_a.busy, 1'b0);
        check1("rst valid", if_a.valid, 1'b0);
        check1("rst ovf", if_a.overflow, 1'b0);

        // First conversion starts on the first edge after release.
        run_conv(0, 1'b1);
        for (int i = 1; i < 9; i++) begin
            run_conv(i, 1'b0);
        end

        // Unchanged input: no new conversion.
        repeat (3) @(posedge clk); #1;
        check1("idle no_restart", if_a.busy, 1'b0);

        // Change 5 -> 7 during conversion.
        @(negedge clk);
        set_val(32'd5);
        @(posedge clk);                           // edge E
        repeat (9) @(posedge clk);                // edge E+9
        @(negedge clk);
        set_val(32'd7);                           // sampled at E+10, ignored
        repeat (24) @(posedge clk); #1;           // edge E+33
        check56("mid first_result", if_a.hex_out, {{7{7'h7F}}, 7'h12});
        check1("mid busy_e33", if_a.busy, 1'b0);
        @(posedge clk); #1;                       // edge E+34
        check1("mid restart", if_a.busy, 1'b1);
        repeat (32) @(posedge clk); #1;           // edge E+66
        check56("mid hold_e66", if_a.hex_out, {{7{7'h7F}}, 7'h12});
        @(posedge clk); #1;                       // edge E+67
        check56("mid second_result", if_a.hex_out, {{7{7'h7F}}, 7'h78});

        // Reset in the middle of converting 0; value left unchanged afterwards.
        @(negedge clk);
        set_val(32'd0);
        @(posedge clk);                           // edge E
        repeat (15) @(posedge clk); #1;           // edge E+15
        check1("rstmid busy_before", if_a.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check56("rstmid hex_a", if_a.hex_out, {56{1'b1}});
        check56("rstmid hex_c", if_c.hex_out, 56'h0);
        check1("rstmid valid", if_a.valid, 1'b0);
        check1("rstmid busy", if_a.busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;                       // edge E'
        check1("pend busy_start", if_a.busy, 1'b1);
        repeat (32) @(posedge clk); #1;           // edge E'+32
        check1("pend valid_e32", if_a.valid, 1'b0);
        @(posedge clk); #1;                       // edge E'+33
        check1("pend valid", if_a.valid, 1'b1);
        check56("pend hex_a", if_a.hex_out, {{7{7'h7F}}, 7'h40});
        check56("pend hex_b", if_b.hex_out, {8{7'h40}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
